// File: rtl/sramlike_axi_bridge.sv
// sramlike_axi_bridge: bridges an SRAM-like instruction port and an SRAM-like
// data port onto a single AXI3-style master with one outstanding read and one
// outstanding write. Data reads win arbitration over instruction reads.
// Optional macro BRIDGE_RAW_CHECK_EN holds off data reads that hit the word
// of a pending write (read-after-write hazard blocking).
module sramlike_axi_bridge (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;

    localparam logic [ID_W-1:0] INST_ID  = ID_W'(0);
    localparam logic [ID_W-1:0] DATA_ID  = ID_W'(1);
    localparam logic [ID_W-1:0] WRITE_ID = ID_W'(1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_size;
    logic [ID_W-1:0]   rd_id;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_size;
    logic [DATA_W-1:0] wr_data;
    logic              aw_done;
    logic              w_done;

    logic raw_hazard;
    logic data_rd_ok;
    logic data_wr_ok;
    logic r_hs;
    logic r_data_hit;
    logic r_inst_hit;
    logic b_hs;

    // Response status and unused request fields carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{inst_wdata, rresp, rlast, bid, bresp};

    // Read-after-write hazard: same word as a write still in flight.
`ifdef BRIDGE_RAW_CHECK_EN
    assign raw_hazard = (w_state != W_IDLE) && (data_addr[31:2] == wr_addr[31:2]);
`else
    assign raw_hazard = 1'b0;
`endif

    // Request acceptance; gated by reset so nothing is acknowledged while held.
    always_comb begin
        data_rd_ok   = 1'b0;
        data_wr_ok   = 1'b0;
        inst_addr_ok = 1'b0;
        if (!reset) begin
            data_rd_ok   = data_req && !data_wr && (r_state == R_IDLE) && !raw_hazard;
            data_wr_ok   = data_req && data_wr && (w_state == W_IDLE);
            inst_addr_ok = inst_req && !inst_wr && (r_state == R_IDLE)
                           && !(data_req && !data_wr);
        end
        data_addr_ok = data_rd_ok || data_wr_ok;
    end

    // Response steering; a data read response always beats a write response.
    assign r_hs         = rvalid && rready;
    assign r_data_hit   = r_hs && (rid == DATA_ID);
    assign r_inst_hit   = r_hs && (rid == INST_ID);
    assign bready       = (w_state == W_B) && !r_data_hit;
    assign b_hs         = bvalid && bready;
    assign inst_data_ok = r_inst_hit;
    assign data_data_ok = r_data_hit || b_hs;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    // Read FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state and AR/R handshake outputs.
    always_comb begin
        r_next  = r_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        case (r_state)
            R_IDLE: if (data_rd_ok || inst_addr_ok) r_next = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_next = R_R;
            end
            R_R: begin
                rready = 1'b1;
                if (rvalid) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Capture the accepted read request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
            rd_size <= '0;
            rd_id   <= '0;
        end else if (data_rd_ok) begin
            rd_addr <= data_addr;
            rd_size <= data_size;
            rd_id   <= DATA_ID;
        end else if (inst_addr_ok) begin
            rd_addr <= inst_addr;
            rd_size <= inst_size;
            rd_id   <= INST_ID;
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state; AW and W channels retire independently.
    always_comb begin
        w_next  = w_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        case (w_state)
            W_IDLE: if (data_wr_ok) w_next = W_REQ;
            W_REQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready)))
                    w_next = W_B;
            end
            W_B: if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Remember which of AW/W has already handshaken for the current write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (w_state != W_REQ) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
        end
    end

    // Capture the accepted write request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr <= '0;
            wr_size <= '0;
            wr_data <= '0;
        end else if (data_wr_ok) begin
            wr_addr <= data_addr;
            wr_size <= data_size;
            wr_data <= data_wdata;
        end
    end

    // Byte strobes from transfer size and low address bits.
    always_comb begin
        case (wr_size)
            2'd0:    wstrb = 4'b0001 << wr_addr[1:0];
            2'd1:    wstrb = 4'b0011 << wr_addr[1:0];
            default: wstrb = 4'b1111;
        endcase
    end

    // AXI request fields: single-beat INCR, no lock/cache/prot attributes.
    assign arid    = rd_id;
    assign araddr  = rd_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, rd_size};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = WRITE_ID;
    assign awaddr  = wr_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, wr_size};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid     = WRITE_ID;
    assign wdata   = wr_data;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Self-checking bench for sramlike_axi_bridge. Expected data_ok responses are
// queued when the AXI response is driven and consumed by a negedge monitor.
module tb_sramlike_axi_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready;
    logic        arready = 0, rvalid = 0, rlast = 0, awready = 0, wready = 0, bvalid = 0;
    logic [3:0]  rid = 0, bid = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] data;
    } exp_t;

    logic [31:0] exp_inst[$];
    exp_t        exp_data[$];
    logic [31:0] ei;
    exp_t        ed;
    int n_tests = 0;
    int n_fail = 0;
    int n_inst_ok = 0;
    int n_data_ok = 0;

    sramlike_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    // Scoreboard: every data_ok pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (inst_data_ok === 1'b1) begin
            n_inst_ok++;
            n_tests++;
            if (exp_inst.size() == 0) begin
                n_fail++;
                $display("FAIL inst_data_ok_unexpected: got pulse rdata=%h, expected none", inst_rdata);
            end else begin
                ei = exp_inst.pop_front();
                if (inst_rdata !== ei) begin n_fail++; $display("FAIL inst_rdata: got %h expected %h", inst_rdata, ei); end
            end
        end
        if (data_data_ok === 1'b1) begin
            n_data_ok++;
            n_tests++;
            if (exp_data.size() == 0) begin
                n_fail++;
                $display("FAIL data_data_ok_unexpected: got pulse, expected none");
            end else begin
                ed = exp_data.pop_front();
                if ((bvalid && bready) !== ed.is_wr) begin n_fail++; $display("FAIL data_ok_source: got b=%b expected b=%b", bvalid && bready, ed.is_wr); end
                else if (!ed.is_wr && data_rdata !== ed.data) begin n_fail++; $display("FAIL data_rdata: got %h expected %h", data_rdata, ed.data); end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (exp_inst.size() != 0 || exp_data.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: got inst=%0d data=%0d pending, expected 0", name, exp_inst.size(), exp_data.size());
        end
    endtask

    task automatic test_reset();
        inst_req = 1; data_req = 1; data_wr = 0;
        @(negedge clk);
        n_tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL rst_addr_ok: got %b expected 00", {inst_addr_ok, data_addr_ok}); end
        n_tests++; if ({arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok} !== 7'd0) begin n_fail++; $display("FAIL rst_valids: got %b expected 0", {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}); end
        n_tests++; if ({araddr, awaddr, wdata, arid} !== 100'd0) begin n_fail++; $display("FAIL rst_fields: got %h %h %h %h expected 0", araddr, awaddr, wdata, arid); end
        step();
        reset = 0; inst_req = 0; data_req = 0;
        @(negedge clk);
        n_tests++; if ({arlen, arburst, arlock, arcache, arprot} !== {8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin n_fail++; $display("FAIL ar_const: got %h/%b/%b/%h/%h expected 0/01/00/0/0", arlen, arburst, arlock, arcache, arprot); end
        n_tests++; if ({awlen, awburst, awlock, awcache, awprot} !== {8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin n_fail++; $display("FAIL aw_const: got %h/%b/%b/%h/%h expected 0/01/00/0/0", awlen, awburst, awlock, awcache, awprot); end
        n_tests++; if ({awid, wid, wlast} !== {4'd1, 4'd1, 1'b1}) begin n_fail++; $display("FAIL w_const: got awid=%h wid=%h wlast=%b expected 1 1 1", awid, wid, wlast); end
    endtask

    task automatic test_inst_read();
        int base;
        step();
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC00000; arready = 1;
        @(negedge clk);
        n_tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL inst_accept: got %b expected 10", {inst_addr_ok, data_addr_ok}); end
        step();
        inst_req = 0;
        @(negedge clk);
        n_tests++; if ({arvalid, rready} !== 2'b10) begin n_fail++; $display("FAIL inst_ar_valid: got %b expected 10", {arvalid, rready}); end
        n_tests++; if ({araddr, arid, arsize} !== {32'hBFC00000, 4'd0, 3'd2}) begin n_fail++; $display("FAIL inst_ar_fields: got %h %h %h expected bfc00000 0 2", araddr, arid, arsize); end
        step();
        arready = 0;
        @(negedge clk);
        n_tests++; if ({arvalid, rready} !== 2'b01) begin n_fail++; $display("FAIL inst_r_wait: got %b expected 01", {arvalid, rready}); end
        base = n_inst_ok;
        step();
        rvalid = 1; rid = 0; rdata = 32'h3C1A0000; exp_inst.push_back(32'h3C1A0000);
        @(negedge clk);
        n_tests++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL inst_data_ok: got %b expected 1", inst_data_ok); end
        step();
        rvalid = 0;
        @(negedge clk);
        n_tests++; if ((n_inst_ok - base) != 1 || rready !== 1'b0) begin n_fail++; $display("FAIL inst_one_pulse: got %0d pulses rready=%b expected 1 pulse rready=0", n_inst_ok - base, rready); end
        check_drained("inst_read");
    endtask

    task automatic test_arbitration();
        step();
        inst_req = 1; inst_size = 2; inst_addr = 32'h1FC00010;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h00001000; arready = 1;
        @(negedge clk);
        n_tests++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL arb_data_wins: got %b expected 10", {data_addr_ok, inst_addr_ok}); end
        step();
        data_req = 0;
        @(negedge clk);
        n_tests++; if ({arvalid, arid, araddr, inst_addr_ok} !== {1'b1, 4'd1, 32'h00001000, 1'b0}) begin n_fail++; $display("FAIL arb_data_ar: got v=%b id=%h a=%h iok=%b expected 1 1 00001000 0", arvalid, arid, araddr, inst_addr_ok); end
        step();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'hCAFEF00D; exp_data.push_back('{1'b0, 32'hCAFEF00D});
        @(negedge clk);
        n_tests++; if ({inst_addr_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL arb_inst_held: got %b expected 01", {inst_addr_ok, data_data_ok}); end
        step();
        rvalid = 0; arready = 1;
        @(negedge clk);
        n_tests++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL arb_inst_after: got %b expected 1", inst_addr_ok); end
        step();
        inst_req = 0;
        @(negedge clk);
        n_tests++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h1FC00010}) begin n_fail++; $display("FAIL arb_inst_ar: got v=%b id=%h a=%h expected 1 0 1fc00010", arvalid, arid, araddr); end
        step();
        arready = 0; rvalid = 1; rid = 0; rdata = 32'h24080001; exp_inst.push_back(32'h24080001);
        step();
        rvalid = 0;
        @(negedge clk);
        check_drained("arbitration");
    endtask

    task automatic test_byte_store();
        int base;
        step();
        data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80000003; data_wdata = 32'h000000AB; awready = 1;
        @(negedge clk);
        n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL store_accept: got %b expected 1", data_addr_ok); end
        step();
        data_req = 0;
        @(negedge clk);
        n_tests++; if ({awvalid, wvalid, wstrb} !== {1'b1, 1'b1, 4'b1000}) begin n_fail++; $display("FAIL store_req: got aw=%b w=%b strb=%b expected 1 1 1000", awvalid, wvalid, wstrb); end
        n_tests++; if ({awaddr, awsize, wdata} !== {32'h80000003, 3'd0, 32'h000000AB}) begin n_fail++; $display("FAIL store_fields: got %h %h %h expected 80000003 0 000000ab", awaddr, awsize, wdata); end
        step();
        awready = 0;
        @(negedge clk);
        n_tests++; if ({awvalid, wvalid} !== 2'b01) begin n_fail++; $display("FAIL store_aw_drop: got %b expected 01", {awvalid, wvalid}); end
        step();
        @(negedge clk);
        n_tests++; if ({awvalid, wvalid, bready} !== 3'b010) begin n_fail++; $display("FAIL store_w_wait: got %b expected 010", {awvalid, wvalid, bready}); end
        step();
        wready = 1;
        step();
        wready = 0;
        @(negedge clk);
        n_tests++; if ({wvalid, bready, data_data_ok} !== 3'b010) begin n_fail++; $display("FAIL store_wait_b: got %b expected 010", {wvalid, bready, data_data_ok}); end
        base = n_data_ok;
        step();
        bvalid = 1; bid = 1; exp_data.push_back('{1'b1, 32'h0});
        step();
        bvalid = 0;
        @(negedge clk);
        n_tests++; if ((n_data_ok - base) != 1 || bready !== 1'b0) begin n_fail++; $display("FAIL store_one_pulse: got %0d pulses bready=%b expected 1 pulse bready=0", n_data_ok - base, bready); end
        check_drained("byte_store");
    endtask

    task automatic test_collision();
        step();
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80002000; data_wdata = 32'h11223344; awready = 1; wready = 1;
        @(negedge clk);
        n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL coll_wr_accept: got %b expected 1", data_addr_ok); end
        step();
        data_req = 0;
        @(negedge clk);
        n_tests++; if ({awvalid, wvalid, wstrb} !== {2'b11, 4'b1111}) begin n_fail++; $display("FAIL coll_word_strb: got %b %b expected 11 1111", {awvalid, wvalid}, wstrb); end
        step();
        awready = 0; wready = 0;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80003000; arready = 1;
        @(negedge clk);
        n_tests++; if ({awvalid, wvalid, bready, data_addr_ok} !== 4'b0011) begin n_fail++; $display("FAIL coll_wb_rd_accept: got %b expected 0011", {awvalid, wvalid, bready, data_addr_ok}); end
        step();
        data_req = 0;
        step();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'h5A5A1234; bvalid = 1; bid = 1;
        exp_data.push_back('{1'b0, 32'h5A5A1234});
        exp_data.push_back('{1'b1, 32'h0});
        @(negedge clk);
        n_tests++; if ({bready, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL coll_first: got bready=%b ok=%b expected 0 1", bready, data_data_ok); end
        step();
        rvalid = 0;
        @(negedge clk);
        n_tests++; if ({bready, data_data_ok} !== 2'b11) begin n_fail++; $display("FAIL coll_second: got bready=%b ok=%b expected 1 1", bready, data_data_ok); end
        step();
        bvalid = 0;
        @(negedge clk);
        n_tests++; if ({bready, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL coll_done: got %b expected 00", {bready, data_data_ok}); end
        check_drained("collision");
    endtask

    task automatic test_raw();
        step();
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL raw_wr_accept: got %b expected 1", data_addr_ok); end
        step();
        data_wr = 0; data_size = 1; data_addr = 32'h80001002;
`ifdef BRIDGE_RAW_CHECK_EN
        @(negedge clk);
        n_tests++; if (data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL raw_block_req: got %b expected 0", data_addr_ok); end
        step();
        awready = 1; wready = 1;
        step();
        awready = 0; wready = 0;
        @(negedge clk);
        n_tests++; if ({bready, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL raw_block_b: got %b expected 10", {bready, data_addr_ok}); end
        step();
        bvalid = 1; exp_data.push_back('{1'b1, 32'h0});
        @(negedge clk);
        n_tests++; if (data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL raw_block_bhs: got %b expected 0", data_addr_ok); end
        step();
        bvalid = 0;
        @(negedge clk);
        n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b expected 1", data_addr_ok); end
        step();
        data_req = 0; arready = 1;
        @(negedge clk);
        n_tests++; if ({arvalid, araddr, arsize} !== {1'b1, 32'h80001002, 3'd1}) begin n_fail++; $display("FAIL raw_ar: got %b %h %h expected 1 80001002 1", arvalid, araddr, arsize); end
        step();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'h0000BEEF; exp_data.push_back('{1'b0, 32'h0000BEEF});
        step();
        rvalid = 0;
        @(negedge clk);
`else
        @(negedge clk);
        n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL raw_no_block: got %b expected 1", data_addr_ok); end
        step();
        data_req = 0; arready = 1;
        @(negedge clk);
        n_tests++; if ({arvalid, araddr, arsize} !== {1'b1, 32'h80001002, 3'd1}) begin n_fail++; $display("FAIL raw_ar: got %b %h %h expected 1 80001002 1", arvalid, araddr, arsize); end
        step();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'h0000BEEF; exp_data.push_back('{1'b0, 32'h0000BEEF});
        step();
        rvalid = 0; awready = 1; wready = 1;
        @(negedge clk);
        n_tests++; if ({awvalid, wvalid} !== 2'b11) begin n_fail++; $display("FAIL raw_wr_pending: got %b expected 11", {awvalid, wvalid}); end
        step();
        awready = 0; wready = 0; bvalid = 1; exp_data.push_back('{1'b1, 32'h0});
        step();
        bvalid = 0;
        @(negedge clk);
`endif
        check_drained("raw");
    endtask

    task automatic test_reset_mid();
        step();
        inst_req = 1; inst_size = 2; inst_addr = 32'hBFC00100; arready = 1;
        @(negedge clk);
        n_tests++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL mid_accept: got %b expected 1", inst_addr_ok); end
        step();
        inst_req = 0;
        step();
        arready = 0;
        @(negedge clk);
        n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL mid_in_r: got rready=%b expected 1", rready); end
        @(posedge clk);
        #2;
        reset = 1;
        #1;
        n_tests++; if ({rready, arvalid} !== 2'b00) begin n_fail++; $display("FAIL mid_async: got rready=%b arvalid=%b expected 0 0", rready, arvalid); end
        step();
        reset = 0;
        @(negedge clk);
        n_tests++; if (araddr !== 32'h0) begin n_fail++; $display("FAIL mid_addr_cleared: got %h expected 0", araddr); end
        step();
        rvalid = 1; rid = 0; rdata = 32'h0BADF00D;
        @(negedge clk);
        n_tests++; if ({inst_data_ok, rready} !== 2'b00) begin n_fail++; $display("FAIL mid_late_r: got ok=%b rready=%b expected 0 0", inst_data_ok, rready); end
        step();
        rvalid = 0;
        @(negedge clk);
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_arbitration();
        test_byte_store();
        test_collision();
        test_raw();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sramlike_axi_bridge.md
SRAMLIKE_AXI_BRIDGE -- requirements
Module: sramlike_axi_bridge

Interface
REQ-001 The block SHALL have no parameters; all AXI widths SHALL be fixed (32-bit address and data, 4-bit IDs).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 inst_req/inst_wr/inst_size[1:0]/inst_addr[31:0]/inst_wdata[31:0]  in  SRAM-like instruction request.
REQ-005 inst_rdata[31:0]/inst_addr_ok/inst_data_ok  out  SRAM-like instruction response.
REQ-006 data_req/data_wr/data_size[1:0]/data_addr[31:0]/data_wdata[31:0]  in  SRAM-like data request.
REQ-007 data_rdata[31:0]/data_addr_ok/data_data_ok  out  SRAM-like data response.
REQ-008 AR: arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid  out; arready  in.
REQ-009 R: rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in; rready  out.
REQ-010 AW: same field set and widths as AR, prefixed aw  out; awready  in.
REQ-011 W: wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid  out; wready  in.
REQ-012 B: bid[3:0], bresp[1:0], bvalid  in; bready  out.

Function
REQ-013 Constant outputs SHALL be: arlen = awlen = 0, arburst = awburst = 2'b01, lock = cache = prot = 0, awid = wid = 1, wlast = 1.
REQ-014 Read FSM states SHALL be R_IDLE, R_AR and R_R. R_IDLE->R_AR on an accepted read. R_AR->R_R on arvalid & arready. R_R->R_IDLE on rvalid & rready.
REQ-015 Write FSM states SHALL be W_IDLE, W_REQ and W_B. W_IDLE->W_REQ on an accepted write. W_REQ->W_B once both the AW and the W handshakes have completed, in either order or in the same cycle. W_B->W_IDLE on bvalid & bready.
REQ-016 In W_REQ, awvalid and wvalid SHALL deassert independently, in the cycle after their own handshake.
REQ-017 data_addr_ok (read) SHALL equal data_req & ~data_wr & read FSM in R_IDLE (further gated per REQ-032).
REQ-018 inst_addr_ok SHALL equal inst_req & ~inst_wr & read FSM in R_IDLE & ~(data_req & ~data_wr); data reads win arbitration.
REQ-019 data_addr_ok (write) SHALL equal data_req & data_wr & write FSM in W_IDLE; inst_wr = 1 SHALL never be accepted.
REQ-020 On acceptance, address, size, wdata and ID SHALL be registered; read ID SHALL be 0 for inst and 1 for data.
REQ-021 arsize/awsize SHALL equal {1'b0, size}; araddr/awaddr SHALL equal the registered address unmodified.
REQ-022 wstrb SHALL be: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; size 2 -> 4'b1111.
REQ-023 arvalid SHALL be asserted exactly in R_AR; rready SHALL be asserted exactly in R_R.
REQ-024 inst_data_ok SHALL equal rvalid & rready & rid==0; inst_rdata SHALL equal rdata in that cycle (zero latency from R).
REQ-025 data_data_ok SHALL pulse for one cycle on rvalid & rready & rid==1 (data_rdata = rdata), or on bvalid & bready.
REQ-026 bready SHALL equal (W_B) & ~(rvalid & rready & rid==1); a write response SHALL never collide with a data read response.
REQ-027 rresp and bresp SHALL be ignored.

Reset
REQ-028 While reset is high, both FSMs SHALL be IDLE and every valid/ready/ok output SHALL be 0.
REQ-029 All registered address, data and ID fields SHALL reset to 0.
REQ-030 Reset asserted mid-transaction SHALL abandon it; no data_ok SHALL be produced for it after release.

Configuration
REQ-031 Macro BRIDGE_RAW_CHECK_EN SHALL select read-after-write hazard blocking.
REQ-032 Defined: a data read SHALL NOT be accepted while the write FSM is not in W_IDLE and addr[31:2] matches the pending write address; it SHALL be accepted in the cycle after W_B->W_IDLE. Inst reads are unaffected.
REQ-033 Undefined: no address comparison; read acceptance SHALL depend only on REQ-017/REQ-018.

Verification
REQ-034 Inst read 0xBFC00000 with arready=1 and rvalid two cycles later carrying 0x3C1A0000 -> arid=0, arsize=2, one inst_data_ok, inst_rdata=0x3C1A0000.
REQ-035 Simultaneous inst and data read requests -> data_addr_ok=1, inst_addr_ok=0; inst is accepted only after data's R handshake.
REQ-036 Byte store, addr 0x...03, wdata 0x000000AB; wready asserted 3 cycles after awready -> wstrb=4'b1000; exactly one data_data_ok after bvalid.
REQ-037 rvalid (rid=1) and bvalid in the same cycle -> bready=0 that cycle; two data_data_ok pulses on consecutive cycles.
REQ-038 With BRIDGE_RAW_CHECK_EN, store 0x80001000 pending and a load from 0x80001002 -> load held off until write returns to IDLE; without the macro, the load is accepted immediately.
REQ-039 Reset pulsed while in R_R -> rready=0 and arvalid=0 immediately; no inst_data_ok when a late rvalid arrives.
